// File: rtl/icfo_pkg.sv
// Shared constants for the integer-CFO peak search: default widths and
// the FSM state encoding used by icfo_peak_search.
package icfo_pkg;

   localparam int ICFO_WIDTH  = 16;
   localparam int ICFO_N_BINS = 64;
   localparam int ICFO_IDX_W  = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_REPORT = 2'd2
   } icfo_state_t;

endpackage

// File: rtl/icfo_max_track.sv
// Running-maximum tracker: holds the largest magnitude seen in the current
// window and the bin index where it first appeared.
module icfo_max_track #(
   parameter int MAG_W = 17,
   parameter int IDX_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_val,
   input  logic [MAG_W-1:0] i_mag,
   input  logic [IDX_W-1:0] i_idx,
   output logic [MAG_W-1:0] o_max,
   output logic [IDX_W-1:0] o_idx,
   output logic [MAG_W-1:0] o_nxt_max,
   output logic [IDX_W-1:0] o_nxt_idx
);

   logic [MAG_W-1:0] r_max;
   logic [IDX_W-1:0] r_idx;
   logic             w_load;

   // Strict compare keeps the first occurrence on ties.
   assign w_load    = i_val && (i_mag > r_max);
   assign o_nxt_max = w_load ? i_mag : r_max;
   assign o_nxt_idx = w_load ? i_idx : r_idx;
   assign o_max     = r_max;
   assign o_idx     = r_idx;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_max <= '0;
         r_idx <= '0;
      end else if (i_clr) begin
         r_max <= '0;
         r_idx <= '0;
      end else begin
         r_max <= o_nxt_max;
         r_idx <= o_nxt_idx;
      end
   end

endmodule

// File: rtl/icfo_peak_search.sv
// Integer-CFO peak search: scans one window of N_BINS approximate magnitudes,
// reports the strongest bin, its signed subcarrier offset and a threshold hit.
module icfo_peak_search
   import icfo_pkg::*;
#(
   parameter int WIDTH  = ICFO_WIDTH,
   parameter int N_BINS = ICFO_N_BINS,
   parameter int IDX_W  = ICFO_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH:0]   mag_in,
   input  logic             mag_val,
   input  logic [WIDTH:0]   thresh,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] peak_idx,
   output logic [WIDTH:0]   peak_mag,
   output logic [IDX_W-1:0] icfo,
   output logic             found
);

   localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_BINS - 1);

   icfo_state_t      r_state, w_state_nxt;
   logic [IDX_W-1:0] r_cnt;
   logic [WIDTH:0]   r_thresh;
   logic [IDX_W-1:0] r_peak_idx, r_icfo;
   logic [WIDTH:0]   r_peak_mag;
   logic             r_found;

   logic             w_clr, w_acc, w_last;
   logic [WIDTH:0]   w_max, w_nxt_max;
   logic [IDX_W-1:0] w_idx, w_nxt_idx, w_icfo;

   // start restarts from IDLE or SEARCH and beats a coincident sample.
   assign w_clr  = start && (r_state != ST_REPORT);
   assign w_acc  = (r_state == ST_SEARCH) && mag_val && !start;
   assign w_last = w_acc && (r_cnt == LAST_BIN);

   icfo_max_track #(
      .MAG_W (WIDTH + 1),
      .IDX_W (IDX_W)
   ) u_max (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_clr     (w_clr),
      .i_val     (w_acc),
      .i_mag     (mag_in),
      .i_idx     (r_cnt),
      .o_max     (w_max),
      .o_idx     (w_idx),
      .o_nxt_max (w_nxt_max),
      .o_nxt_idx (w_nxt_idx)
   );

   // Upper half of the bins wraps to negative offsets: idx - N_BINS mod 2^IDX_W.
   assign w_icfo = w_nxt_idx[IDX_W-1] ? IDX_W'(int'(w_nxt_idx) - N_BINS) : w_nxt_idx;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_SEARCH;
         ST_SEARCH: begin
            if (start)       w_state_nxt = ST_SEARCH;
            else if (w_last) w_state_nxt = ST_REPORT;
         end
         ST_REPORT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_thresh <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_clr) begin
            r_cnt    <= '0;
            r_thresh <= thresh;
         end else if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Results land on the same edge that enters REPORT, using the final sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_peak_idx <= '0;
         r_peak_mag <= '0;
         r_icfo     <= '0;
         r_found    <= 1'b0;
      end else if (w_last) begin
         r_peak_idx <= w_nxt_idx;
         r_peak_mag <= w_nxt_max;
         r_icfo     <= w_icfo;
         r_found    <= (w_nxt_max > r_thresh);
      end
   end

   assign busy     = (r_state == ST_SEARCH);
   assign done     = (r_state == ST_REPORT);
   assign peak_idx = r_peak_idx;
   assign peak_mag = r_peak_mag;
   assign icfo     = r_icfo;
   assign found    = r_found;

   logic w_unused;
   assign w_unused = ^{w_max, w_idx};

endmodule

// File: tb/tb_icfo_peak_search.sv
// Bench for icfo_peak_search: table-driven windows with a result scoreboard,
// plus hand sequences for abort, start-in-REPORT and async reset.
module tb_icfo_peak_search;

   localparam int WIDTH  = 16;
   localparam int N_BINS = 64;
   localparam int IDX_W  = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH:0]   mag_in;
   logic             mag_val;
   logic [WIDTH:0]   thresh;
   logic             busy, done, found;
   logic [IDX_W-1:0] peak_idx, icfo;
   logic [WIDTH:0]   peak_mag;

   icfo_peak_search #(.WIDTH(WIDTH), .N_BINS(N_BINS), .IDX_W(IDX_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mag_in   (mag_in),
      .mag_val  (mag_val),
      .thresh   (thresh),
      .busy     (busy),
      .done     (done),
      .peak_idx (peak_idx),
      .peak_mag (peak_mag),
      .icfo     (icfo),
      .found    (found)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH:0]   thresh;
      logic [WIDTH:0]   base;
      int               b0;
      logic [WIDTH:0]   v0;
      int               b1;
      logic [WIDTH:0]   v1;
      bit               stall;
      logic [IDX_W-1:0] e_idx;
      logic [WIDTH:0]   e_mag;
      logic [IDX_W-1:0] e_icfo;
      logic             e_found;
   } vec_t;

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic [WIDTH:0]   mag;
      logic [IDX_W-1:0] icfo;
      logic             found;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[8];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_done = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH:0] mag_of(input vec_t v, input int i);
      if (i == v.b0) return v.v0;
      if (i == v.b1) return v.v1;
      return v.base;
   endfunction

   // Scoreboard side: every done pulse must match the oldest pending result.
   always @(negedge clk) begin
      if (rst && done) begin
         exp_t e;
         n_done++;
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("peak_idx", 32'(peak_idx), 32'(e.idx));
            chk("peak_mag", 32'(peak_mag), 32'(e.mag));
            chk("icfo",     32'(icfo),     32'(e.icfo));
            chk("found",    32'(found),    32'(e.found));
         end
      end
   end

   // Drives a start (optionally with a coincident sample) then a full window.
   task automatic run_window(input vec_t v, input bit push, input bit coinc, input bit start_in_rep);
      exp_t e;
      @(posedge clk); #1;
      start   = 1'b1;
      thresh  = v.thresh;
      mag_val = coinc;
      mag_in  = 17'h1FFFF;
      if (push) begin
         e.idx = v.e_idx; e.mag = v.e_mag; e.icfo = v.e_icfo; e.found = v.e_found;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < N_BINS; i++) begin
         mag_in  = mag_of(v, i);
         mag_val = 1'b1;
         @(posedge clk); #1;
         if (v.stall && (i % 7 == 6) && i != N_BINS - 1) begin
            mag_val = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("busy_in_gap", 32'(busy), 32'd1);
               chk("no_early_done", 32'(done), 32'd0);
               @(posedge clk); #1;
            end
         end
      end
      mag_val = 1'b0;
      if (start_in_rep) start = 1'b1;
      @(negedge clk);
      chk("done_latency", 32'(done), 32'd1);
      chk("busy_in_report", 32'(busy), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("done_single_cycle", 32'(done), 32'd0);
      if (start_in_rep) chk("start_in_report_ignored", 32'(busy), 32'd0);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic feed_partial(input int n, input int pk, input logic [WIDTH:0] pv);
      @(posedge clk); #1;
      start = 1'b1; thresh = 17'd0; mag_val = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         mag_in  = (i == pk) ? pv : 17'd10;
         mag_val = 1'b1;
         @(posedge clk); #1;
      end
      mag_val = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   d0;
      vec_t vr;

      //           thresh    base   b0  v0        b1  v1    stall idx       mag        icfo      found
      vecs[0] = '{17'd100,  17'd10, 5,  17'd500,  -1, 17'd0,   0, 6'd5,     17'd500,   6'd5,     1'b1};
      vecs[1] = '{17'd400,  17'd20, 60, 17'd300,  62, 17'd300, 0, 6'd60,    17'd300,   6'b111100, 1'b0};
      vecs[2] = '{17'd100,  17'd10, 5,  17'd500,  -1, 17'd0,   1, 6'd5,     17'd500,   6'd5,     1'b1};
      vecs[3] = '{17'd0,    17'd0,  -1, 17'd0,    -1, 17'd0,   0, 6'd0,     17'd0,     6'd0,     1'b0};
      vecs[4] = '{17'h1FFFE,17'd7,  63, 17'h1FFFF,-1, 17'd0,   0, 6'd63,    17'h1FFFF, 6'h3F,    1'b1};
      vecs[5] = '{17'd50,   17'd1,  0,  17'd50,   -1, 17'd0,   0, 6'd0,     17'd50,    6'd0,     1'b0};
      vecs[6] = '{17'd8,    17'd3,  32, 17'd9,    -1, 17'd0,   0, 6'd32,    17'd9,     6'b100000, 1'b1};
      vecs[7] = '{17'd999,  17'd2,  31, 17'd1000, 40, 17'd999, 0, 6'd31,    17'd1000,  6'd31,    1'b1};

      // Reset, then idle with mag_val but no start.
      rst = 1'b0; start = 1'b0; mag_in = '0; mag_val = 1'b0; thresh = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_peak_idx", 32'(peak_idx), 32'd0);
      chk("rst_peak_mag", 32'(peak_mag), 32'd0);
      chk("rst_icfo", 32'(icfo), 32'd0);
      chk("rst_found", 32'(found), 32'd0);
      rst = 1'b1;
      mag_in = 17'd1234; mag_val = 1'b1;
      repeat (100) @(negedge clk);
      mag_val = 1'b0;
      chk("idle_no_done", 32'(n_done), 32'd0);
      chk("idle_not_busy", 32'(busy), 32'd0);

      for (int v = 0; v < 8; v++) run_window(vecs[v], 1'b1, 1'b0, 1'b0);

      // start during REPORT must not restart a search.
      run_window(vecs[0], 1'b1, 1'b0, 1'b1);

      // Abort after 30 samples, restart; only the second window reports.
      vr = '{17'd100, 17'd10, 40, 17'd200, -1, 17'd0, 0, 6'd40, 17'd200, 6'b101000, 1'b1};
      d0 = n_done;
      feed_partial(30, 2, 17'd900);
      chk("abort_busy", 32'(busy), 32'd1);
      run_window(vr, 1'b1, 1'b0, 1'b0);
      chk("abort_one_done", 32'(n_done - d0), 32'd1);

      // Restart coincident with the 64th sample: start wins, no done.
      d0 = n_done;
      feed_partial(63, 3, 17'd5000);
      run_window(vecs[6], 1'b1, 1'b1, 1'b0);
      chk("start_priority_one_done", 32'(n_done - d0), 32'd1);

      // Async reset mid-search clears without a clock edge.
      feed_partial(20, 4, 17'd777);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_peak_idx", 32'(peak_idx), 32'd0);
      chk("arst_peak_mag", 32'(peak_mag), 32'd0);
      chk("arst_icfo", 32'(icfo), 32'd0);
      chk("arst_found", 32'(found), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_window(vecs[1], 1'b1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
